steer_en_ctrl: RTL
==================

STEER_EN_CTRL -- requirements
Module: steer_en_ctrl

Interface
REQ-001 SHALL have parameter LC_W, default 12, load-cell sample width.
REQ-002 SHALL have parameter MIN_RIDER_WT, default 12'h200, nominal minimum rider weight (sum units).
REQ-003 SHALL have parameter WT_HYST, default 12'h40, hysteresis on the weight threshold.
REQ-004 SHALL have parameter TMR_CYCLES, default 65_000_000, settle time in clocks (1.3 s at 50 MHz).
REQ-005 SHALL have parameter STEPOFF_N, default 4, consecutive step-off samples required to leave STEER.
REQ-006 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port lft_ld  input  LC_W  left load-cell sample.
REQ-009 SHALL have port rght_ld  input  LC_W  right load-cell sample.
REQ-010 SHALL have port ld_vld  input  1  one-cycle strobe: new lft_ld/rght_ld pair valid.
REQ-011 SHALL have port en_steer  output  1  steering enabled, to balance control.
REQ-012 SHALL have port rider_off  output  1  no rider present.
REQ-013 SHALL have port settling  output  1  rider on, settle timer running.

Function
REQ-014 SHALL capture lft_ld/rght_ld into internal registers on each clk edge with ld_vld=1; SHALL assert internal smp_new for exactly the following cycle.
REQ-015 SHALL compute sum = lft+rght at LC_W+1 bits, no overflow; diff = |lft-rght| at LC_W bits, both from the captured registers.
REQ-016 SHALL derive: sum_gt_min = sum > MIN_RIDER_WT+WT_HYST; sum_lt_min = sum < MIN_RIDER_WT-WT_HYST; diff_gt_1_4 = diff > (sum>>2); diff_gt_15_16 = diff > sum-(sum>>4); all comparisons unsigned, truncating shifts.
REQ-017 SHALL implement a 3-state FSM: IDLE, WAIT, STEER; outputs Moore-decoded: rider_off = IDLE, settling = WAIT, en_steer = STEER.
REQ-018 IDLE: sum_gt_min -> WAIT with timer cleared; otherwise remain.
REQ-019 WAIT, priority order: !sum_gt_min -> IDLE; diff_gt_1_4 -> remain, timer cleared; timer full -> STEER; otherwise remain, timer incrementing.
REQ-020 Timer SHALL be 0 on entry to WAIT, increment once per clock in WAIT, saturate at its terminal count, and assert full when equal to the terminal count.
REQ-021 STEER: sum_lt_min -> IDLE, with priority over step-off; on a smp_new cycle with diff_gt_15_16 and step-off count = STEPOFF_N-1 -> WAIT with timer cleared; otherwise remain.
REQ-022 Step-off count SHALL increment on smp_new with diff_gt_15_16, clear on smp_new without diff_gt_15_16, and clear whenever state is not STEER.
REQ-023 Weight between the two hysteresis thresholds SHALL cause no transition out of STEER and no entry from IDLE.
REQ-024 Latency: a sample captured at edge N SHALL produce its state change, and matching output change, at edge N+1.
REQ-025 IDLE and WAIT SHALL evaluate flags every cycle; only the STEER step-off path is gated by smp_new.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE, timer 0, step-off count 0, and captured samples 0.
REQ-027 Output values during and after reset: rider_off=1, en_steer=0, settling=0; a reset mid-WAIT or mid-STEER SHALL behave identically.

Configuration
REQ-028 Macro STEER_FAST_SIM_EN defined: timer terminal count SHALL be 1023, so full is asserted 1023 cycles after WAIT entry, and the timer width SHALL be 10 bits.
REQ-029 Macro STEER_FAST_SIM_EN undefined: terminal count SHALL be TMR_CYCLES-1, with the timer sized $clog2(TMR_CYCLES) bits; all other behaviour SHALL be identical.

Verification (defaults, STEER_FAST_SIM_EN defined; thresholds: gt 0x240, lt 0x1C0)
REQ-030 Reset asserted mid-STEER -> same cycle rider_off=1, en_steer=0, settling=0.
REQ-031 lft=rght=0x130 strobed -> settling=1 one edge later; en_steer=1 after 1024 more cycles; rider_off=0 throughout.
REQ-032 In STEER, strobe sum 0x200 -> en_steer stays 1; strobe sum 0x1B0 -> rider_off=1 one edge later.
REQ-033 In WAIT, lft=0x200, rght=0x060 (diff 0x1A0 > 0x98) held 5000 cycles -> en_steer never 1; then balanced 0x130/0x130 -> en_steer=1 after 1024 cycles.
REQ-034 In STEER, lft=0x250, rght=0x008 (diff 0x248 > 0x233) strobed 3 times -> en_steer=1; 4th strobe -> settling=1 and en_steer=0 one edge later.
REQ-035 In STEER, 3 step-off strobes, 1 balanced strobe, then 3 step-off strobes -> en_steer remains 1 (count cleared).

Source files
------------

// File: rtl/steer_en_ctrl.sv
// -----------------------------------------------------------------------------
// steer_en_ctrl
//   Rider-detect / steering-enable controller. Captures load-cell sample pairs,
//   derives weight and balance flags from them, and sequences a three-state
//   controller: no rider (IDLE) -> rider settling (WAIT) -> steering (STEER).
//
//   Parameters
//     LC_W          load-cell sample width
//     MIN_RIDER_WT  nominal minimum rider weight (sum units)
//     WT_HYST       hysteresis around MIN_RIDER_WT
//     TMR_CYCLES    settle time in clocks
//     STEPOFF_N     consecutive step-off samples needed to leave STEER
//
//   Ports
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     lft_ld     left load-cell sample
//     rght_ld    right load-cell sample
//     ld_vld     one-cycle strobe, lft_ld/rght_ld pair valid
//     en_steer   steering enabled (STEER)
//     rider_off  no rider present (IDLE)
//     settling   rider on, settle timer running (WAIT)
//
//   Configuration macro
//     STEER_FAST_SIM_EN  shortens the settle timer to a 10-bit, 1023-count
//                        timer for simulation; otherwise TMR_CYCLES is used.
// -----------------------------------------------------------------------------
module steer_en_ctrl #(
    parameter int unsigned LC_W         = 12,
    parameter int unsigned MIN_RIDER_WT = 12'h200,
    parameter int unsigned WT_HYST      = 12'h40,
    parameter int unsigned TMR_CYCLES   = 65_000_000,
    parameter int unsigned STEPOFF_N    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LC_W-1:0] lft_ld,
    input  logic [LC_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic            settling
);

    localparam int unsigned SUM_W = LC_W + 1;

`ifdef STEER_FAST_SIM_EN
    localparam int unsigned TMR_W  = 10;
    localparam int unsigned TMR_TC = 1023;
`else
    localparam int unsigned TMR_W  = $clog2(TMR_CYCLES);
    localparam int unsigned TMR_TC = TMR_CYCLES - 1;
`endif

    localparam logic [TMR_W-1:0] TMR_FULL = TMR_W'(TMR_TC);

    // Count must be able to hold STEPOFF_N for the one cycle it takes the
    // state to leave STEER after the final step-off sample.
    localparam int unsigned      SO_W    = $clog2(STEPOFF_N + 1);
    localparam logic [SO_W-1:0]  SO_LAST = SO_W'(STEPOFF_N - 1);

    localparam logic [SUM_W-1:0] TH_HI = SUM_W'(MIN_RIDER_WT + WT_HYST);
    localparam logic [SUM_W-1:0] TH_LO = SUM_W'(MIN_RIDER_WT - WT_HYST);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        STEER = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [LC_W-1:0]   lft_r, rght_r;
    logic              smp_new;
    logic [TMR_W-1:0]  tmr;
    logic              tmr_full;
    logic              tmr_clr;
    logic [SO_W-1:0]   so_cnt;

    logic [SUM_W-1:0]  sum;
    logic [LC_W-1:0]   diff;
    logic              sum_gt_min, sum_lt_min;
    logic              diff_gt_1_4, diff_gt_15_16;

    // Sample capture; smp_new marks the cycle after a capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_r   <= '0;
            rght_r  <= '0;
            smp_new <= 1'b0;
        end else begin
            smp_new <= ld_vld;
            if (ld_vld) begin
                lft_r  <= lft_ld;
                rght_r <= rght_ld;
            end
        end
    end

    always_comb begin
        sum  = {1'b0, lft_r} + {1'b0, rght_r};
        diff = (lft_r >= rght_r) ? (lft_r - rght_r) : (rght_r - lft_r);
        sum_gt_min    = sum > TH_HI;
        sum_lt_min    = sum < TH_LO;
        diff_gt_1_4   = {1'b0, diff} > (sum >> 2);
        diff_gt_15_16 = {1'b0, diff} > (sum - (sum >> 4));
    end

    assign tmr_full = (tmr == TMR_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tmr_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (sum_gt_min) begin
                    state_nxt = WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            WAIT: begin
                if (!sum_gt_min)
                    state_nxt = IDLE;
                else if (diff_gt_1_4)
                    tmr_clr = 1'b1;
                else if (tmr_full)
                    state_nxt = STEER;
            end
            STEER: begin
                if (sum_lt_min)
                    state_nxt = IDLE;
                else if (smp_new && diff_gt_15_16 && (so_cnt == SO_LAST)) begin
                    state_nxt = WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Settle timer: cleared on WAIT entry or imbalance, saturates at full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tmr <= '0;
        else if (tmr_clr)
            tmr <= '0;
        else if (state == WAIT && !tmr_full)
            tmr <= tmr + 1'b1;
    end

    // Consecutive step-off sample counter, only live in STEER.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            so_cnt <= '0;
        else if (state != STEER)
            so_cnt <= '0;
        else if (smp_new)
            so_cnt <= diff_gt_15_16 ? so_cnt + 1'b1 : '0;
    end

    assign rider_off = (state == IDLE);
    assign settling  = (state == WAIT);
    assign en_steer  = (state == STEER);

endmodule
